// File: rtl/dm_pkg.sv
// Shared constants, state encoding and latency helper for the data-memory responder.
package dm_pkg;
    localparam int DM_ADDR_W = 7;
    localparam int DM_DATA_W = 32;
    localparam int DM_DEPTH  = 2 ** DM_ADDR_W;
    localparam int RL_MIN    = 1;
    localparam int RL_MAX    = 3;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } dm_state_e;

    // Out-of-range latencies fall back to the nearest legal depth.
    function automatic int rl_clamp(input int lat);
        if (lat < RL_MIN) return RL_MIN;
        if (lat > RL_MAX) return RL_MAX;
        return lat;
    endfunction
endpackage

// File: rtl/dm_if.sv
// Processor data-memory port: access request from the master, read result and ready from the slave.
interface dm_if
    import dm_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W,
    parameter int DATA_W = DM_DATA_W
);
    logic              ena;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;
    logic              rd_valid;
    logic              ready;

    modport master (output ena, wea, addra, dina, input douta, rd_valid, ready);
    modport slave  (input ena, wea, addra, dina, output douta, rd_valid, ready);
endinterface

// File: rtl/dm_read_pipe.sv
// Read-result delay line: LAT register stages carrying {valid, data}; the last stage holds its data between results.
module dm_read_pipe #(
    parameter int DATA_W = 32,
    parameter int LAT    = 1
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] douta,
    output logic              rd_valid
);
    logic [LAT-1:0]             vld_pipe;
    logic [LAT-1:0][DATA_W-1:0] dat_pipe;

    // Data only moves alongside a valid, so bubbles never disturb a held result.
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[0] <= in_valid;
            if (in_valid) dat_pipe[0] <= in_data;
            for (int i = 1; i < LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign douta    = dat_pipe[LAT-1];
    assign rd_valid = vld_pipe[LAT-1];
endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: zero-fill sweep after reset, then single-port read/write with pipelined reads.
// Optional DM_ACCESS_COUNT_EN adds saturating rd_count/wr_count outputs.
module dm_responder
    import dm_pkg::*;
#(
    parameter int ADDR_W         = DM_ADDR_W,
    parameter int DATA_W         = DM_DATA_W,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        sysclk,
    input  logic        rst,
    dm_if.slave         bus
`ifdef DM_ACCESS_COUNT_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LAT   = rl_clamp(READ_LATENCY);

    dm_state_e         state;
    logic [ADDR_W-1:0] clr_addr;
    logic              ready_q;
    logic              rd_acc;
    logic              wr_acc;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem [DEPTH];

    // ready_q gates acceptance; it also covers the first cycle after reset when no sweep is configured.
    assign rd_acc = ready_q & bus.ena & ~bus.wea;
    assign wr_acc = ready_q & bus.ena & bus.wea;
    assign bus.ready = ready_q;

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_addr <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (&clr_addr) begin
                        state   <= ST_READY;
                        ready_q <= 1'b1;
                    end
                end
                ST_READY: ready_q <= 1'b1;
                default:  state   <= ST_CLEAR;
            endcase
        end
    end

    // The sweep borrows the single write port; Processor traffic is locked out until it finishes.
    assign mem_we = (state == ST_CLEAR) | wr_acc;
    assign mem_wa = (state == ST_CLEAR) ? clr_addr : bus.addra;
    assign mem_wd = (state == ST_CLEAR) ? '0 : bus.dina;

    always_ff @(posedge sysclk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    dm_read_pipe #(
        .DATA_W(DATA_W),
        .LAT   (LAT)
    ) u_pipe (
        .sysclk  (sysclk),
        .rst     (rst),
        .in_valid(rd_acc),
        .in_data (mem[bus.addra]),
        .douta   (bus.douta),
        .rd_valid(bus.rd_valid)
    );

`ifdef DM_ACCESS_COUNT_EN
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_acc && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            if (wr_acc && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dm_responder.sv
// Bench: two responders (READ_LATENCY 1 and 3) share stimulus; per-instance scoreboards check every cycle.
module tb_dm_responder;
    logic        sysclk = 1'b0;
    logic        rst    = 1'b1;
    logic        ena    = 1'b0;
    logic        wea    = 1'b0;
    logic [6:0]  addra  = '0;
    logic [31:0] dina   = '0;
    int          cyc    = 0;
    int          tests  = 0;
    int          fails  = 0;
    bit          mon_en = 1'b0;

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    dm_if #(.ADDR_W(7), .DATA_W(32)) bus1 ();
    dm_if #(.ADDR_W(7), .DATA_W(32)) bus3 ();
    assign bus1.ena = ena;  assign bus1.wea = wea;  assign bus1.addra = addra;  assign bus1.dina = dina;
    assign bus3.ena = ena;  assign bus3.wea = wea;  assign bus3.addra = addra;  assign bus3.dina = dina;

`ifdef DM_ACCESS_COUNT_EN
    logic [15:0] rdc1, wrc1, rdc3, wrc3;
`endif

    dm_responder #(.ADDR_W(7), .DATA_W(32), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_rl1 (
        .sysclk(sysclk), .rst(rst), .bus(bus1)
`ifdef DM_ACCESS_COUNT_EN
        , .rd_count(rdc1), .wr_count(wrc1)
`endif
    );
    dm_responder #(.ADDR_W(7), .DATA_W(32), .READ_LATENCY(3), .CLEAR_ON_RESET(1)) u_rl3 (
        .sysclk(sysclk), .rst(rst), .bus(bus3)
`ifdef DM_ACCESS_COUNT_EN
        , .rd_count(rdc3), .wr_count(wrc3)
`endif
    );

    typedef struct {
        logic        ena;
        logic        wea;
        logic [6:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sbq[2][$];
    logic [31:0] last[2];
    int          lat[2] = '{1, 3};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Result due in cycle `due` must appear exactly then; otherwise rd_valid=0 and douta holds.
    task automatic mon(input int id, input logic rv, input logic [31:0] dq);
        exp_t e;
        if (!rst) begin
            check($sformatf("rst_rd_valid%0d", id), {31'b0, rv}, 32'd0);
            check($sformatf("rst_douta%0d", id), dq, 32'd0);
            last[id] = '0;
        end else if (sbq[id].size() > 0 && sbq[id][0].due == cyc) begin
            e = sbq[id].pop_front();
            check($sformatf("rd_valid%0d", id), {31'b0, rv}, 32'd1);
            check($sformatf("rd_data%0d", id), dq, e.data);
            last[id] = e.data;
        end else begin
            check($sformatf("idle_rd_valid%0d", id), {31'b0, rv}, 32'd0);
            check($sformatf("douta_hold%0d", id), dq, last[id]);
        end
    endtask

    always @(negedge sysclk) begin
        if (mon_en) begin
            mon(0, bus1.rd_valid, bus1.douta);
            mon(1, bus3.rd_valid, bus3.douta);
        end
    end

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge sysclk); #1;
        ena = v.ena; wea = v.wea; addra = v.addr; dina = v.data;
        if (v.ena && !v.wea) begin
            for (int k = 0; k < 2; k++) begin
                e.data = v.exp;
                e.due  = cyc + lat[k];
                sbq[k].push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        vec_t v;
        v = '{1'b0, 1'b0, 7'h00, 32'h0, 32'h0};
        for (int k = 0; k < n; k++) apply(v);
    endtask

    // Release reset, read then write addr 5 during the sweep, and time the sweep.
    task automatic release_and_sweep(input string name);
        int n;
        n = 0;
        @(negedge sysclk); #1;
        ena = 1'b1; wea = 1'b0; addra = 7'h05; dina = 32'hBAD0_0000;
        rst = 1'b1;
        while (!bus1.ready && n < 400) begin
            @(posedge sysclk); #1;
            n++;
            wea  = (n >= 64);
            dina = 32'hBAD0_0000 + n;
        end
        ena = 1'b0; wea = 1'b0;
        check({name, "_sweep_cycles"}, n, 128);
        check({name, "_ready3"}, {31'b0, bus3.ready}, 32'd1);
    endtask

    vec_t tbl[19];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 7'h10, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 7'h10, 32'h0,        32'hDEADBEEF};
        tbl[2]  = '{1'b1, 1'b1, 7'h01, 32'h11,       32'h0};
        tbl[3]  = '{1'b1, 1'b1, 7'h02, 32'h22,       32'h0};
        tbl[4]  = '{1'b1, 1'b1, 7'h03, 32'h33,       32'h0};
        tbl[5]  = '{1'b1, 1'b0, 7'h01, 32'h0,        32'h11};
        tbl[6]  = '{1'b1, 1'b0, 7'h02, 32'h0,        32'h22};
        tbl[7]  = '{1'b1, 1'b0, 7'h03, 32'h0,        32'h33};
        tbl[8]  = '{1'b0, 1'b0, 7'h03, 32'h0,        32'h0};
        tbl[9]  = '{1'b1, 1'b0, 7'h7F, 32'h0,        32'h0};
        tbl[10] = '{1'b1, 1'b0, 7'h00, 32'h0,        32'h0};
        tbl[11] = '{1'b1, 1'b0, 7'h05, 32'h0,        32'h0};
        tbl[12] = '{1'b1, 1'b1, 7'h7F, 32'hA5A5A5A5, 32'h0};
        tbl[13] = '{1'b0, 1'b1, 7'h7F, 32'hFFFFFFFF, 32'h0};
        tbl[14] = '{1'b1, 1'b0, 7'h7F, 32'h0,        32'hA5A5A5A5};
        tbl[15] = '{1'b1, 1'b1, 7'h00, 32'h12345678, 32'h0};
        tbl[16] = '{1'b1, 1'b1, 7'h00, 32'hCAFEF00D, 32'h0};
        tbl[17] = '{1'b1, 1'b0, 7'h00, 32'h0,        32'hCAFEF00D};
        tbl[18] = '{1'b1, 1'b0, 7'h10, 32'h0,        32'hDEADBEEF};

        #2 rst = 1'b0;
        repeat (2) @(negedge sysclk);
        check("reset_ready1", {31'b0, bus1.ready}, 32'd0);
        check("reset_ready3", {31'b0, bus3.ready}, 32'd0);
        mon_en = 1'b1;

        release_and_sweep("first");
        for (int i = 0; i < 19; i++) apply(tbl[i]);
        idle(5);

        // Two reads in flight on the latency-3 instance when reset hits.
        apply('{1'b1, 1'b0, 7'h10, 32'h0, 32'hDEADBEEF});
        apply('{1'b1, 1'b0, 7'h01, 32'h0, 32'h11});
        @(negedge sysclk); #1;
        ena = 1'b0;
        rst = 1'b0;
        sbq[0].delete();
        sbq[1].delete();
        repeat (3) @(negedge sysclk);
        check("midreset_ready3", {31'b0, bus3.ready}, 32'd0);
        release_and_sweep("second");

        for (int i = 0; i < 5; i++)
            apply('{1'b1, 1'b1, 7'(8'h20 + i), 32'hC0DE_0000 + i, 32'h0});
        for (int i = 0; i < 5; i++)
            apply('{1'b1, 1'b0, 7'(8'h20 + i), 32'h0, 32'hC0DE_0000 + i});
        apply('{1'b1, 1'b0, 7'h10, 32'h0, 32'h0});
        apply('{1'b1, 1'b0, 7'h7F, 32'h0, 32'h0});
        idle(6);

`ifdef DM_ACCESS_COUNT_EN
        check("rd_count1", {16'b0, rdc1}, 32'd7);
        check("wr_count1", {16'b0, wrc1}, 32'd5);
        check("rd_count3", {16'b0, rdc3}, 32'd7);
        check("wr_count3", {16'b0, wrc3}, 32'd5);
`endif
        mon_en = 1'b0;
        check("sb_drain1", sbq[0].size(), 0);
        check("sb_drain3", sbq[1].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
